// File: rtl/uart_in_responder.sv
// UART input responder: a host-filled character FIFO that answers core-side
// read queries one cycle later, returning EMPTY_CH whenever nothing is queued.
module uart_in_responder #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] EMPTY_CH = 8'hFF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [7:0]               push_ch,
  output logic                     push_ready,
  input  logic                     flush,
  input  logic                     io_uart_in_valid,
  output logic                     io_uart_in_resp_valid,
  output logic [7:0]               io_uart_in_ch,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [31:0]              query_cnt,
  output logic [31:0]              miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          resp_valid_q, resp_valid_d;
  logic [7:0]    ch_q, ch_d;
  logic [31:0]   query_q, query_d;
  logic [31:0]   miss_q, miss_d;

  logic push_ready_s;
  logic fifo_empty_s;
  logic do_push_s;
  logic do_pop_s;

  // Ready looks only at the registered occupancy, so a full FIFO never
  // accepts a character even when a same-cycle pop would free a slot.
  assign push_ready_s = (count_q != FULL_C);
  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign do_push_s    = push_valid && push_ready_s && !flush;
  assign do_pop_s     = io_uart_in_valid && !fifo_empty_s && !flush;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    resp_valid_d = 1'b0;
    ch_d         = ch_q;
    query_d      = query_q;
    miss_d       = miss_q;

    if (io_uart_in_valid) begin
      resp_valid_d = 1'b1;
      query_d      = query_q + 32'd1;
      if (do_pop_s) begin
        ch_d = mem_q[head_q];
      end else begin
        ch_d   = EMPTY_CH;
        miss_d = miss_q + 32'd1;
      end
    end else begin
      ch_d = ch_q;
    end

    if (flush) begin
      head_d     = {AW{1'b0}};
      tail_d     = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (do_push_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (do_pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (push_valid && !push_ready_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q       <= {AW{1'b0}};
      tail_q       <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      overflow_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      ch_q         <= 8'h00;
      query_q      <= 32'd0;
      miss_q       <= 32'd0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      resp_valid_q <= resp_valid_d;
      ch_q         <= ch_d;
      query_q      <= query_d;
      miss_q       <= miss_d;
    end
  end

  // Storage is deliberately left without reset; occupancy guards every read.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[tail_q] <= push_ch;
    end
  end

  assign push_ready            = push_ready_s;
  assign io_uart_in_resp_valid = resp_valid_q;
  assign io_uart_in_ch         = ch_q;
  assign count                 = count_q;
  assign overflow              = overflow_q;
  assign query_cnt             = query_q;
  assign miss_cnt              = miss_q;

endmodule

// File: tb/tb_uart_in_responder.sv
// Scoreboard bench for uart_in_responder: a reference FIFO predicts every
// response when the query is driven; a monitor pops and compares each pulse.
module tb_uart_in_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic [7:0]  push_ch = 8'h00;
  logic        push_ready;
  logic        flush = 1'b0;
  logic        io_uart_in_valid = 1'b0;
  logic        io_uart_in_resp_valid;
  logic [7:0]  io_uart_in_ch;
  logic [4:0]  count;
  logic        overflow;
  logic [31:0] query_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  logic        m_ovf = 1'b0;
  logic [31:0] m_query = 32'd0;
  logic [31:0] m_miss = 32'd0;

  uart_in_responder #(.DEPTH(16), .EMPTY_CH(8'hFF)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .push_valid            (push_valid),
    .push_ch               (push_ch),
    .push_ready            (push_ready),
    .flush                 (flush),
    .io_uart_in_valid      (io_uart_in_valid),
    .io_uart_in_resp_valid (io_uart_in_resp_valid),
    .io_uart_in_ch         (io_uart_in_ch),
    .count                 (count),
    .overflow              (overflow),
    .query_cnt             (query_cnt),
    .miss_cnt              (miss_cnt)
  );

  always #5 clock = ~clock;

  // Every response must appear exactly one edge after its query.
  always @(posedge clock) begin
    #1;
    if (io_uart_in_resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got pulse with ch %h, expected no response", io_uart_in_ch);
      end else begin
        mon_exp = exp_q.pop_front();
        if (io_uart_in_ch !== mon_exp) begin
          errors++;
          $display("FAIL resp_ch: got %h, expected %h", io_uart_in_ch, mon_exp);
        end
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      errors++;
      mon_exp = exp_q.pop_front();
      $display("FAIL resp_missing: got no pulse, expected ch %h", mon_exp);
    end
  end

  task automatic drive(input logic pv, input logic [7:0] pc, input logic q, input logic fl);
    int sz;
    @(negedge clock);
    push_valid       = pv;
    push_ch          = pc;
    io_uart_in_valid = q;
    flush            = fl;
    sz = model_q.size();
    if (q) begin
      m_query++;
      if (fl || sz == 0) begin
        exp_q.push_back(8'hFF);
        m_miss++;
      end else begin
        exp_q.push_back(model_q.pop_front());
      end
    end
    if (fl) begin
      model_q.delete();
      m_ovf = 1'b0;
    end else if (pv) begin
      if (sz < 16) model_q.push_back(pc);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({io_uart_in_resp_valid, io_uart_in_ch, count, overflow, push_ready} !== {1'b0, 8'h00, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got rv=%b ch=%h cnt=%0d ovf=%b rdy=%b, expected 0/00/0/0/1",
               io_uart_in_resp_valid, io_uart_in_ch, count, overflow, push_ready);
    end
    checks++;
    if (query_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got q=%0d m=%0d, expected 0/0", query_cnt, miss_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    drive(1'b1, 8'h62, 1'b0, 1'b0);
    drive(1'b1, 8'h63, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || query_cnt !== 32'd3 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL basic_status: got cnt=%0d q=%0d m=%0d, expected 0/3/0", count, query_cnt, miss_cnt);
    end
  endtask

  task automatic test_empty_push;
    drive(1'b1, 8'h41, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd1 || miss_cnt !== 32'd1 || query_cnt !== 32'd4) begin
      errors++;
      $display("FAIL empty_push_status: got cnt=%0d m=%0d q=%0d, expected 1/1/4", count, miss_cnt, query_cnt);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || miss_cnt !== 32'd1) begin
      errors++;
      $display("FAIL empty_push_drain: got cnt=%0d m=%0d, expected 0/1", count, miss_cnt);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 17; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (push_ready !== 1'b0 || overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_full: got rdy=%b ovf=%b cnt=%0d, expected 0/1/16", push_ready, overflow, count);
    end
    for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || overflow !== 1'b1 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got cnt=%0d ovf=%b rdy=%b, expected 0/1/1", count, overflow, push_ready);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd16) begin
      errors++;
      $display("FAIL wrap_fill: got cnt=%0d, expected 16", count);
    end
    for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL wrap_drain: got cnt=%0d, expected 0", count);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got cnt=%0d ovf=%b, expected 5/1", count, overflow);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || overflow !== 1'b0 || miss_cnt !== m_miss) begin
      errors++;
      $display("FAIL flush_post: got cnt=%0d ovf=%b m=%0d, expected 0/0/%0d", count, overflow, miss_cnt, m_miss);
    end
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL flush_push: got cnt=%0d, expected 0", count);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 8'hC0, 1'b0, 1'b0);
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'hC2 + 8'(i), 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd2) begin
      errors++;
      $display("FAIL b2b_count: got cnt=%0d, expected 2", count);
    end
    repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || query_cnt !== m_query || miss_cnt !== m_miss) begin
      errors++;
      $display("FAIL b2b_counters: got cnt=%0d q=%0d m=%0d, expected 0/%0d/%0d",
               count, query_cnt, miss_cnt, m_query, m_miss);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    io_uart_in_valid = 1'b0;
    exp_q.delete();
    model_q.delete();
    m_query = 32'd0;
    m_miss  = 32'd0;
    m_ovf   = 1'b0;
    #1;
    checks++;
    if ({io_uart_in_resp_valid, io_uart_in_ch, count, overflow} !== {1'b0, 8'h00, 5'd0, 1'b0}
        || query_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got rv=%b ch=%h cnt=%0d ovf=%b q=%0d m=%0d, expected all zero",
               io_uart_in_resp_valid, io_uart_in_ch, count, overflow, query_cnt, miss_cnt);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd0 || query_cnt !== 32'd0 || io_uart_in_ch !== 8'h00) begin
      errors++;
      $display("FAIL post_reset: got cnt=%0d q=%0d ch=%h, expected 0/0/00", count, query_cnt, io_uart_in_ch);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_push();
    test_overflow();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
